// File: rtl/wrr_arbiter_pkg.sv
// wrr_arbiter_pkg: shared helpers for the weighted round-robin arbiter
package wrr_arbiter_pkg;
  function automatic int idw_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  function automatic int eff_weight(input logic [31:0] w);
    return (w == 0) ? 1 : int'(w);
  endfunction
  function automatic int onehot_to_bin(input logic [31:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if (oh[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/wrr_arbiter_pick.sv
// rr_pick: masked find-first, falling back to the lowest requester when the mask window is empty
module rr_pick import wrr_arbiter_pkg::*; #(
  parameter int NREQ = 4,
  localparam int IDW = idw_of(NREQ)
) (
  input  logic [NREQ-1:0] request,
  input  logic [NREQ-1:0] mask,
  output logic [NREQ-1:0] pick,
  output logic [IDW-1:0]  pick_id,
  output logic            any
);
  logic [NREQ-1:0] src;
  always_comb begin
    src = |(request & mask) ? (request & mask) : request;
    pick = src & (~src + NREQ'(1));
    pick_id = IDW'(onehot_to_bin(32'(pick)));
    any = |request;
  end
endmodule

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter with valid/ready grant, burst credits and packet lock
module wrr_arbiter import wrr_arbiter_pkg::*; #(
  parameter int NREQ = 4,
  parameter int WEIGHT_W = 4,
  localparam int IDW = idw_of(NREQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          request,
  input  logic [NREQ*WEIGHT_W-1:0] weight,
  input  logic                     lock,
  input  logic                     ready,
  output logic [NREQ-1:0]          grant,
  output logic [IDW-1:0]           grant_id,
  output logic                     grant_valid
);
  logic                active, active_n, locked, locked_n;
  logic [IDW-1:0]      owner, owner_n;
  logic [WEIGHT_W-1:0] credit, credit_n, pick_w;
  logic [NREQ-1:0]     mask, mask_n, pick;
  logic [IDW-1:0]      pick_id;
  logic                any, hold, gv, xfer;

  function automatic logic [NREQ-1:0] above(input logic [IDW-1:0] i);
    return {NREQ{1'b1}} << (int'(i) + 1);
  endfunction

  rr_pick #(.NREQ(NREQ)) u_pick (
    .request(request),
    .mask(mask),
    .pick(pick),
    .pick_id(pick_id),
    .any(any)
  );

  always_comb begin
    hold = active & (request[owner] | locked);
    gv = hold ? request[owner] : any;
    xfer = gv & ready;
    pick_w = WEIGHT_W'(eff_weight(32'(weight[pick_id*WEIGHT_W +: WEIGHT_W])));
    active_n = active;
    owner_n = owner;
    credit_n = credit;
    mask_n = mask;
    locked_n = locked;
    if (hold) begin
      if (xfer) begin
        credit_n = (credit == '0) ? '0 : credit - WEIGHT_W'(1);
        locked_n = lock;
        if (credit <= WEIGHT_W'(1) && !lock) begin
          active_n = 1'b0;
          mask_n = above(owner);
        end
      end
    end else if (any) begin
      owner_n = pick_id;
      if (active) mask_n = above(owner);
      if (xfer) begin
        credit_n = pick_w - WEIGHT_W'(1);
        locked_n = lock;
        active_n = (pick_w != WEIGHT_W'(1)) || lock;
        if (pick_w == WEIGHT_W'(1) && !lock) mask_n = above(pick_id);
      end else begin
        credit_n = pick_w;
        active_n = 1'b1;
        locked_n = 1'b0;
      end
    end else if (active) begin
      active_n = 1'b0;
      mask_n = above(owner);
    end
    // reset gates the combinational grant so outputs drop without waiting for an edge
    grant_valid = reset & gv;
    grant = !grant_valid ? '0 : hold ? NREQ'(1) << owner : pick;
    grant_id = !grant_valid ? '0 : hold ? owner : pick_id;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      owner <= '0;
      credit <= '0;
      mask <= '0;
      locked <= 1'b0;
    end else begin
      active <= active_n;
      owner <= owner_n;
      credit <= credit_n;
      mask <= mask_n;
      locked <= locked_n;
    end
  end
endmodule

// File: tb/tb_wrr_arbiter.sv
// tb_wrr_arbiter: table vectors, corner sequences and randomized traffic against a rotating-pointer model
module tb_wrr_arbiter;
  logic        clock, reset, lock, ready, grant_valid;
  logic [3:0]  request, grant;
  logic [15:0] weight;
  logic [1:0]  grant_id;
  int tests, fails;
  int m_active, m_owner, m_rem, m_locked, m_ptr;

  typedef struct {logic [3:0] req; logic rdy; logic lck; int eid;} vec_t;
  vec_t tbl[$];

  wrr_arbiter #(.NREQ(4), .WEIGHT_W(4)) dut (
    .clock(clock), .reset(reset), .request(request), .weight(weight), .lock(lock),
    .ready(ready), .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int ew(input int i);
    int w;
    w = int'(weight[i*4 +: 4]);
    return (w == 0) ? 1 : w;
  endfunction

  // rotating priority: scan upward from the slot after the last released owner
  function automatic int mpick(input logic [3:0] r);
    for (int k = 0; k < 4; k++) if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return 0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_owner = 0; m_rem = 0; m_locked = 0; m_ptr = 0;
  endtask

  task automatic model_out(input logic [3:0] r, output logic v, output int id, output logic hold);
    hold = (m_active != 0) && (r[m_owner] || (m_locked != 0));
    v = hold ? r[m_owner] : (r != 4'b0);
    id = !v ? 0 : hold ? m_owner : mpick(r);
  endtask

  task automatic model_step(input logic [3:0] r, input logic rd, input logic lk);
    logic v, hold, rel;
    int id, p;
    model_out(r, v, id, hold);
    if (hold) begin
      if (v && rd) begin
        rel = (m_rem <= 1) && !lk;
        m_rem = (m_rem > 0) ? m_rem - 1 : 0;
        m_locked = int'(lk);
        if (rel) begin m_active = 0; m_ptr = (m_owner + 1) % 4; end
      end
    end else if (r != 4'b0) begin
      p = mpick(r);
      if (m_active != 0) m_ptr = (m_owner + 1) % 4;
      m_owner = p;
      if (rd) begin
        m_rem = ew(p) - 1;
        m_locked = int'(lk);
        if (m_rem == 0 && !lk) begin m_active = 0; m_ptr = (p + 1) % 4; end
        else m_active = 1;
      end else begin
        m_rem = ew(p); m_active = 1; m_locked = 0;
      end
    end else if (m_active != 0) begin
      m_active = 0; m_ptr = (m_owner + 1) % 4;
    end
  endtask

  task automatic expect_out(input string nm, input logic ev, input int eid);
    logic [3:0] eg;
    logic [1:0] ei;
    eg = ev ? 4'(1 << eid) : 4'b0;
    ei = ev ? 2'(eid) : 2'd0;
    tests++;
    if (grant !== eg || grant_id !== ei || grant_valid !== ev) begin
      fails++;
      $display("FAIL %s: got grant=%b id=%0d valid=%b, want grant=%b id=%0d valid=%b",
               nm, grant, grant_id, grant_valid, eg, ei, ev);
    end
  endtask

  // eid: -1 model only, -2 expect no grant, >=0 expected grant_id
  task automatic cyc(input logic [3:0] r, input logic rd, input logic lk, input string nm, input int eid);
    logic v, hold;
    int id;
    request = r; ready = rd; lock = lk;
    #2;
    model_out(r, v, id, hold);
    expect_out({nm, "/model"}, v, id);
    if (eid != -1) expect_out(nm, eid >= 0, (eid >= 0) ? eid : 0);
    @(posedge clock);
    model_step(r, rd, lk);
    #1;
  endtask

  initial begin
    int wseq[12];
    tests = 0; fails = 0;
    wseq = '{0, 1, 1, 1, 2, 3, 3, 0, 1, 1, 1, 2};
    for (int i = 0; i < 8; i++) tbl.push_back('{4'b1111, 1'b1, 1'b0, i % 4});
    for (int i = 0; i < 12; i++) tbl.push_back('{4'b1111, 1'b1, 1'b0, wseq[i]});
    model_reset();
    reset = 1'b0; request = 4'b1111; weight = 16'h1111; ready = 1'b1; lock = 1'b0;
    #7;
    expect_out("reset_hold", 1'b0, 0);
    reset = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 8) weight = {4'd2, 4'd1, 4'd3, 4'd1};
      cyc(tbl[i].req, tbl[i].rdy, tbl[i].lck, (i < 8) ? "rotate" : "weighted", tbl[i].eid);
    end
    weight = 16'h0000;
    cyc(4'b0001, 1'b0, 1'b0, "bp_first", 0);
    cyc(4'b0011, 1'b0, 1'b0, "bp_freeze", 0);
    cyc(4'b0011, 1'b0, 1'b0, "bp_freeze2", 0);
    cyc(4'b0011, 1'b1, 1'b0, "bp_xfer", 0);
    cyc(4'b0011, 1'b1, 1'b0, "bp_next", 1);
    for (int i = 0; i < 3; i++) cyc(4'b0011, 1'b1, 1'b1, "lock_on", 0);
    cyc(4'b0011, 1'b1, 1'b0, "lock_last", 0);
    cyc(4'b0011, 1'b1, 1'b0, "lock_after", 1);
    cyc(4'b0011, 1'b1, 1'b1, "lock_take", 0);
    cyc(4'b0010, 1'b1, 1'b0, "lock_drop", -2);
    cyc(4'b0010, 1'b1, 1'b0, "lock_drop2", -2);
    cyc(4'b0011, 1'b1, 1'b0, "lock_resume", 0);
    cyc(4'b0011, 1'b1, 1'b0, "lock_next", 1);
    weight = 16'h4000;
    cyc(4'b1000, 1'b1, 1'b0, "drop_own3", 3);
    cyc(4'b0001, 1'b1, 1'b0, "drop_move0", 0);
    for (int i = 0; i < 4; i++) cyc(4'b1001, 1'b1, 1'b0, "burst3", 3);
    cyc(4'b1001, 1'b1, 1'b0, "wrap0", 0);
    cyc(4'b1000, 1'b1, 1'b0, "mid_burst", 3);
    cyc(4'b1000, 1'b1, 1'b0, "mid_burst2", 3);
    request = 4'b0110;
    #2;
    reset = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 0);
    model_reset();
    reset = 1'b1;
    cyc(4'b0110, 1'b1, 1'b0, "post_reset", 1);
    for (int s = 0; s < 8; s++) begin
      weight = 16'($urandom);
      for (int c = 0; c < 50; c++)
        cyc(4'($urandom_range(0, 15)), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 1, "rand", -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
Weighted round-robin arbiter with a valid/ready grant handshake, per-requester burst credits and a packet lock. It is the parametrised successor to the team's single-cycle round-robin arbiter. It sits in front of shared resources such as bus ports, memory banks and output queues, where one winner may take several consecutive transfers. Fairness is rotating priority starting after the last released owner.

Parameters:
NREQ, 4, number of requesters (>=2)
WEIGHT_W, 4, width of each per-requester weight field
IDW, $clog2(NREQ), width of grant_id (derived, not overridable)

Ports:
clock  input  1  single clock, all state on posedge
reset  input  1  asynchronous, active-low reset
request  input  NREQ  per-requester request level
weight  input  NREQ*WEIGHT_W  packed weights; field i = weight[i*WEIGHT_W +: WEIGHT_W]; quasi-static
lock  input  1  sampled on transfer; 1 = the current owner keeps the grant past credit exhaustion
ready  input  1  downstream accepts the granted transfer
grant  output  NREQ  one-hot grant, 0 when grant_valid=0
grant_id  output  IDW  binary index of grant, 0 when grant_valid=0
grant_valid  output  1  a grant is presented

Behaviour:
- State registers: active (1), owner (IDW), credit (WEIGHT_W), mask (NREQ), locked (1). All are cleared on reset assertion, with mask=0 meaning the plain lowest-index priority.
- Transfer is defined as grant_valid & ready.
- Eff_weight(i) = weight field i, with a value of 0 treated as 1.
- hold = active & (request[owner] | locked).
- When hold=1:
  - grant = onehot(owner).
  - grant_valid = request[owner].
  - If locked and request[owner]=0, grant_valid=0 and there is no rearbitration.
- When hold=0, a fresh pick is made combinationally:
  - Among mask&request, select the lowest index.
  - If mask&request is empty, fall back to the lowest set bit of request.
  - grant_valid = |request, giving 0-cycle latency from request to grant.
- Fresh pick with transfer:
  - owner <= pick, credit <= eff_weight(pick)-1, locked <= lock.
  - If credit becomes 0 and lock=0: release (active<=0, mask <= bits strictly above pick).
  - Otherwise active <= 1.
- Fresh pick without ready: owner <= pick, active <= 1, credit <= eff_weight(pick), locked <= 0. This freezes the grant, so a newly arriving higher-priority request cannot steal it.
- Held owner with transfer:
  - credit <= credit-1, saturating at 0.
  - locked <= lock.
  - Release when (credit-1)<=0 and lock=0.
- Held owner without transfer: no state change.
- Owner request drop (request[owner]=0 and locked=0): hold=0 and rearbitration happens in the same cycle. A registered release (active<=0, mask above owner) is applied at the next edge.
- Release with mask wrap: owner = NREQ-1 gives mask=0, so the highest index wraps to index 0.
- Weight changes take effect only at the next fresh pick.
- Reset mid-burst: all state clears asynchronously and outputs drop to 0 immediately. After reset, the first pick is the lowest-index requester.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid==|grant.
  - While grant_valid&!ready, grant is stable on the next cycle, provided the owner's request stays high.
- Starvation bound: a continuously requesting input waits at most the sum over other requesters of eff_weight transfers, when lock is never asserted.

Decomposition:
- Package wrr_arbiter_pkg holds:
  - function onehot_to_bin.
  - function eff_weight (the zero-to-one mapping).
  - localparam derivation helpers for IDW.
- One sub-module, rr_pick (NREQ): a combinational masked priority find-first.
  - Inputs: request, mask.
  - Outputs: onehot pick, pick_id, any.
  - This is the only natural split. The FSM and credit logic stay in the top module.

Test Plan:
- Basic rotation: NREQ=4, all weights=1, request=4'b1111, ready=1 for 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3.
- Weighted burst: weights {1,3,1,2} (id0..3), request=1111, ready=1 -> grant_id 0,1,1,1,2,3,3,0,... with each owner getting exactly eff_weight consecutive transfers.
- Backpressure freeze: request=0001 with ready=0 at cycle 0; at cycle 1 request=0011 with ready still 0 -> grant stays 0001 until ready=1. After the transfer the next grant is 0010.
- Lock: weight0=1, request=0011, lock=1 on three transfers then lock=0 -> grant_id 0 for four transfers, then 1. Dropping request[0] while locked -> grant_valid=0, with no grant to id1.
- Early drop and wrap: owner 3 with weight 4 drops request after 1 transfer while request[0]=1 -> grant moves to id0 in the same cycle. Weight 0 behaves as 1.
- Async reset: reset asserted mid-burst, between clock edges -> grant, grant_id and grant_valid go to 0 immediately. After release with request=0110, the first grant_id is 1.
